mmm_serial_core: RTL and testbench
==================================

Name: mmm_serial_core

Overview:
- Bit-serial radix-2 Montgomery modular multiplier core for the RSA datapath.
- Sits directly downstream of the operand-A shift register and consumes its serial output A_bit, LSB first, one bit per enabled cycle.
- Drives that register's load/enable controls.
- Computes result = A*B*R^-1 mod M, with R = 2^N.

Parameters:
- N, 10, operand/modulus width in bits; also the iteration count.
- CW, 4, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstb  input  1  synchronous active-low reset.
- en  input  1  global clock enable; when 0 all state frozen.
- start  input  1  begin multiplication; sampled only in IDLE with en=1.
- B  input  N  operand B; must be held stable from start until done.
- M  input  N  modulus; odd, M > B; must be held stable from start until done.
- A_bit  input  1  serial bit of operand A from the shift register.
- sr_ld  output  1  load strobe to the shift register (its ld_a).
- sr_en  output  1  enable to the shift register (its en).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result is valid from this cycle onward.
- result  output  N  Montgomery product, held until the next done.

Behaviour:
- Reset (rstb=0 at a rising edge): state=IDLE, S=0, cnt=0, result=0, done=0, busy=0.
  - sr_ld and sr_en are combinational from state and are 0 in IDLE.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- en=0: state, S, cnt, result and done all hold; sr_ld=sr_en=0.
  - A done pulse therefore stretches while en=0.
- Whenever en=1, done is cleared at the next edge unless it is being set.
- FSM states: IDLE, LOAD, ITER, REDUCE.
- IDLE: on start=1, go to LOAD; start is ignored in every other state.
- LOAD (1 cycle): sr_ld=1, sr_en=1, so the shift register captures A this edge. Set S=0, cnt=0, go to ITER.
- ITER (N cycles): sr_en=1, sr_ld=0; A_bit holds a_i for i=cnt. Each edge:
  - q = S[0] XOR (a_i AND B[0])
  - S <= (S + (a_i ? B : 0) + (q ? M : 0)) >> 1
  - cnt <= cnt+1
  - After the edge where cnt=N-1, go to REDUCE.
- REDUCE (1 cycle): result <= (S >= M) ? S-M : S, truncated to N bits. done <= 1, go to IDLE.
- busy=1 in LOAD, ITER and REDUCE.
- Widths:
  - S register is N+1 bits; invariant S < 2M.
  - Adder is N+2 bits wide, with no overflow under the preconditions.
  - Comparison and subtraction are N+1 bits.
- Latency: start sampled at edge e0 gives done=1 and a valid result after edge e0+N+2 (12 enabled edges for N=10), with en held at 1.
- Back-to-back operation: start may be asserted in the done cycle, which is state IDLE. The next operation begins with no bubble.
- Preconditions violated (M even, or B >= M): result is undefined but must be X-free. The FSM still completes in N+2 cycles.

Test Plan:
- Reset, then M=1009, A=15, B=15, start -> done exactly 12 cycles after start sampled, result=15; sr_ld high exactly 1 cycle, sr_en high exactly 11 cycles.
- M=1009, A=15, B=7 -> result=7. Then A=1008, B=1008 -> result=740. Then A=0, B=500 -> result=0.
- M=3, A=1, B=1 -> result=1. Issue start again in the done cycle with A=2, B=2 -> second done 12 cycles later, result=1 (4·R^-1 mod 3, with R ≡ 1).
- Deassert en for 5 cycles mid-ITER (M=1009, A=15, B=15) -> no state change and sr_en=0 while en=0; done arrives 17 cycles after start, result=15.
- Pulse start during busy -> ignored; busy/done timing unchanged; result matches the first operation.
- Assert rstb=0 for 1 cycle during ITER -> next cycle busy=0, result=0, no done pulse; a fresh start then completes correctly.

Source files
------------

// File: rtl/mmm_serial_core.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-N mod M.
// Operand A arrives LSB first from an external shift register that this
// core loads and steps through sr_ld/sr_en. B and M are parallel inputs.
//
// Handshake: start is sampled only while idle with en=1. busy is high
// from the following cycle until the operation finishes. done is a
// one-cycle pulse, stretched while en=0. result is valid from done
// onward and is held until the next done. B and M must stay stable
// from start until done.
module mmm_serial_core #(
   parameter int N  = 10,
   parameter int CW = 4
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         en,
   input  logic         start,
   input  logic [N-1:0] B,
   input  logic [N-1:0] M,
   input  logic         A_bit,
   output logic         sr_ld,
   output logic         sr_en,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ITER   = 2'd2,
      REDUCE = 2'd3
   } state_t;

   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   state_t         state, state_nxt;
   logic [N:0]     s_q, s_nxt;
   logic [CW-1:0]  cnt_q, cnt_nxt;
   logic [N-1:0]   result_nxt;
   logic           done_nxt;
   logic           ld_raw, step_raw;

   // Datapath: one Montgomery step and the final conditional subtraction.
   // S < 2M and B < M keep the N+2 bit sum free of overflow.
   logic           q_bit;
   logic [N+1:0]   sum;
   logic [N:0]     s_red;
   logic           unused_bits;

   // Montgomery step and final reduction, shared by ITER and REDUCE.
   always_comb begin
      q_bit = s_q[0] ^ (A_bit & B[0]);
      sum   = {1'b0, s_q}
            + {2'b00, (A_bit ? B : {N{1'b0}})}
            + {2'b00, (q_bit ? M : {N{1'b0}})};
      s_red = (s_q >= {1'b0, M}) ? (s_q - {1'b0, M}) : s_q;
   end

   // sum[0] is always zero after adding q*M; s_red[N] is zero once reduced.
   assign unused_bits = sum[0] ^ s_red[N];

   // Next-state and register-update logic for the four-state sequencer.
   always_comb begin
      state_nxt  = state;
      s_nxt      = s_q;
      cnt_nxt    = cnt_q;
      result_nxt = result;
      done_nxt   = 1'b0;
      ld_raw     = 1'b0;
      step_raw   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            ld_raw    = 1'b1;
            step_raw  = 1'b1;
            s_nxt     = '0;
            cnt_nxt   = '0;
            state_nxt = ITER;
         end
         ITER: begin
            step_raw = 1'b1;
            s_nxt    = sum[N+1:1];
            cnt_nxt  = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) state_nxt = REDUCE;
         end
         REDUCE: begin
            result_nxt = s_red[N-1:0];
            done_nxt   = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift-register controls are suppressed while the core is frozen.
   assign sr_ld     = en & ld_raw;
   assign sr_en     = en & step_raw;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   // State registers: synchronous reset, everything frozen while en=0.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state  <= IDLE;
         s_q    <= '0;
         cnt_q  <= '0;
         result <= '0;
         done   <= 1'b0;
      end else if (en) begin
         state  <= state_nxt;
         s_q    <= s_nxt;
         cnt_q  <= cnt_nxt;
         result <= result_nxt;
         done   <= done_nxt;
      end
   end

endmodule

// File: tb/tb_mmm_serial_core.sv
// Bench for mmm_serial_core: a behavioural operand-A shift register feeds
// the core, a modular-arithmetic reference fills the expected queue.
module tb_mmm_serial_core;
   localparam int N  = 10;
   localparam int CW = 4;

   logic         clk = 1'b0;
   logic         rstb = 1'b0;
   logic         en = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] B = '0;
   logic [N-1:0] M = 10'd1;
   logic         A_bit;
   logic         sr_ld, sr_en, busy, done;
   logic [N-1:0] result;
   logic [1:0]   dbg_state;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] exp_q[$];

   // Operand-A shift register model: load on ld, shift right on en.
   logic [N-1:0] a_val = '0;
   logic [N-1:0] sr_q = '0;
   assign A_bit = sr_q[0];

   int ld_cnt = 0;
   int en_cnt = 0;
   int done_cnt = 0;

   mmm_serial_core #(.N(N), .CW(CW)) dut (
      .clk(clk), .rstb(rstb), .en(en), .start(start), .B(B), .M(M),
      .A_bit(A_bit), .sr_ld(sr_ld), .sr_en(sr_en), .busy(busy),
      .done(done), .result(result), .dbg_state(dbg_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Shift register stub driven by the core's controls.
   always @(posedge clk) begin
      if (sr_en) sr_q <= sr_ld ? a_val : (sr_q >> 1);
   end

   // Strobe counters sampled at the active edge.
   always @(posedge clk) begin
      if (sr_ld) ld_cnt++;
      if (sr_en) en_cnt++;
      if (done && en) done_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   // Reference: the unique r in [0,M) with r*2^N == A*B (mod M).
   function automatic logic [N-1:0] mont_ref(input int m, input int a, input int b);
      int p;
      p = (a * b) % m;
      for (int r = 0; r < m; r++) begin
         if (((r * (1 << N)) % m) == p) return N'(r);
      end
      return '0;
   endfunction

   // Driver: one operation. now=1 asserts start in the current (done)
   // cycle; gap>=0 drops en for 5 cycles; pulse>=0 re-pulses start mid-run.
   task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] a,
                         input logic [N-1:0] b, input bit now, input int gap,
                         input int pulse, output logic [N-1:0] res);
      int cyc;
      int ld0, en0;
      int exp_lat;
      logic [N-1:0] exp_r;
      if (!now) @(negedge clk);
      M = m; B = b; a_val = a;
      exp_q.push_back(mont_ref(int'(m), int'(a), int'(b)));
      ld0 = ld_cnt; en0 = en_cnt;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (done) break;
         en    = !(gap >= 0 && cyc >= gap && cyc < gap + 5);
         start = (cyc == pulse);
      end
      start = 1'b0;
      en = 1'b1;
      exp_lat = (gap >= 0) ? 17 : 12;
      chk("latency", cyc, exp_lat);
      chk("sr_ld_cycles", ld_cnt - ld0, 1);
      chk("sr_en_cycles", en_cnt - en0, 11);
      exp_r = exp_q.pop_front();
      chk("scoreboard_result", result, exp_r);
      res = result;
   endtask

   typedef struct {
      logic [N-1:0] m;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] exp;
      bit           b2b;
   } vec_t;

   vec_t tbl[6];
   logic [N-1:0] res;
   logic [N-1:0] rm, ra, rb;
   int done0;

   initial begin
      tbl[0] = '{m:10'd1009, a:10'd15,   b:10'd15,   exp:10'd15,  b2b:1'b0};
      tbl[1] = '{m:10'd1009, a:10'd15,   b:10'd7,    exp:10'd7,   b2b:1'b0};
      tbl[2] = '{m:10'd1009, a:10'd1008, b:10'd1008, exp:10'd740, b2b:1'b0};
      tbl[3] = '{m:10'd1009, a:10'd0,    b:10'd500,  exp:10'd0,   b2b:1'b0};
      tbl[4] = '{m:10'd3,    a:10'd1,    b:10'd1,    exp:10'd1,   b2b:1'b0};
      tbl[5] = '{m:10'd3,    a:10'd2,    b:10'd2,    exp:10'd1,   b2b:1'b1};

      // Reset state.
      rstb = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_result", result, 0);
      chk("reset_sr_ld", sr_ld, 0);
      chk("reset_sr_en", sr_en, 0);
      chk("reset_state", dbg_state, 0);
      rstb = 1'b1;

      // Directed table, including a back-to-back pair.
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].b2b, -1, -1, res);
         chk("table_result", res, tbl[i].exp);
         if (!(i + 1 < 6 && tbl[i + 1].b2b)) begin
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
         end
      end

      // en dropped for 5 cycles mid-ITER.
      run_op(10'd1009, 10'd15, 10'd15, 1'b0, 4, -1, res);
      chk("gap_result", res, 15);

      // start pulsed while busy is ignored.
      run_op(10'd1009, 10'd15, 10'd7, 1'b0, -1, 3, res);
      chk("pulse_result", res, 7);
      repeat (3) @(negedge clk);
      chk("pulse_no_restart", busy, 0);

      // Reset during ITER aborts without a done pulse.
      @(negedge clk);
      M = 10'd1009; B = 10'd15; a_val = 10'd15; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      done0 = done_cnt;
      rstb = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      chk("abort_done", done, 0);
      repeat (15) @(negedge clk);
      chk("abort_no_done", done_cnt, done0);
      run_op(10'd1009, 10'd15, 10'd15, 1'b0, -1, -1, res);
      chk("after_abort_result", res, 15);

      // Randomized operands against the reference model.
      for (int k = 0; k < 20; k++) begin
         rm = N'($urandom_range(1, 511) * 2 + 1);
         rb = N'($urandom_range(0, int'(rm) - 1));
         ra = N'($urandom_range(0, (1 << N) - 1));
         run_op(rm, ra, rb, 1'b0, ((k % 4) == 1) ? int'($urandom_range(2, 8)) : -1, -1, res);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
